// File: rtl/vote_result_reader.sv
// Scans all four candidates of a voting machine in result mode and
// reports winner mask, maximum count, total votes and tie.
module vote_result_reader #(
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 4,
    parameter int MODE_SETTLE = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] vote_result,
    output logic       mode,
    output logic [4:1] button,
    output logic       busy,
    output logic       done,
    output logic [4:1] winner,
    output logic [7:0] winner_count,
    output logic [9:0] total_votes,
    output logic       tie
);

    localparam int MAX_A = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int MAX_C = (MAX_A > MODE_SETTLE) ? MAX_A : MODE_SETTLE;
    localparam int TW    = (MAX_C > 1) ? $clog2(MAX_C) : 1;

    localparam logic [TW-1:0] SETTLE_LAST = TW'(MODE_SETTLE - 1);
    localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST    = TW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_HOLD,
        S_GAP,
        S_FINISH
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [TW-1:0]   timer;
    logic [1:0]      cand;
    logic [7:0]      count [4];
    logic            timer_done;
    logic            load_results;

    logic [7:0]      max_c;
    logic [9:0]      sum_c;
    logic [4:1]      win_c;
    logic            tie_c;

    always_comb begin
        timer_done = 1'b0;
        unique case (state)
            S_SETTLE: timer_done = (timer == SETTLE_LAST);
            S_HOLD:   timer_done = (timer == HOLD_LAST);
            S_GAP:    timer_done = (timer == GAP_LAST);
            default:  timer_done = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:   if (start) state_nx = S_SETTLE;
            S_SETTLE: if (timer_done) state_nx = S_HOLD;
            S_HOLD:   if (timer_done) state_nx = S_GAP;
            S_GAP:    if (timer_done) state_nx = (cand == 2'd3) ? S_FINISH : S_HOLD;
            S_FINISH: state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        mode   = (state != S_IDLE);
        busy   = (state != S_IDLE);
        done   = (state == S_FINISH);
        button = 4'b0000;
        if (state == S_HOLD) button = 4'b0001 << cand;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            timer <= '0;
            cand  <= 2'd0;
        end else begin
            if (state != state_nx || state == S_IDLE) timer <= '0;
            else                                      timer <= timer + 1'b1;
            if (state == S_IDLE)               cand <= 2'd0;
            else if (state == S_GAP && timer_done) cand <= cand + 2'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) count[i] <= 8'd0;
        end else if (state == S_HOLD && timer_done) begin
            count[cand] <= vote_result;
        end
    end

    always_comb begin
        max_c = count[0];
        for (int i = 1; i < 4; i++)
            if (count[i] > max_c) max_c = count[i];
        sum_c = 10'(count[0]) + 10'(count[1]) + 10'(count[2]) + 10'(count[3]);
        win_c = 4'b0000;
        for (int i = 0; i < 4; i++)
            win_c[i+1] = (count[i] == max_c) && (max_c != 8'd0);
        tie_c = ($countones(win_c) > 1);
    end

    // Candidate 4 is captured before its gap, so all counts are final here.
    assign load_results = (state == S_GAP) && timer_done && (cand == 2'd3);

    always_ff @(posedge clock) begin
        if (reset) begin
            winner       <= 4'b0000;
            winner_count <= 8'd0;
            total_votes  <= 10'd0;
            tie          <= 1'b0;
        end else if (load_results) begin
            winner       <= win_c;
            winner_count <= max_c;
            total_votes  <= sum_c;
            tie          <= tie_c;
        end
    end

endmodule

// File: tb/tb_vote_result_reader.sv
// Scoreboard bench: stimulus pushes expected results, a negedge monitor
// checks the button sequence, handshakes and result registers.
module tb_vote_result_reader;

    localparam int H   = 16;
    localparam int G   = 4;
    localparam int MS  = 4;
    localparam int LAT = 1 + MS + 4 * (H + G);

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] vote_result;
    logic       mode;
    logic [4:1] button;
    logic       busy;
    logic       done;
    logic [4:1] winner;
    logic [7:0] winner_count;
    logic [9:0] total_votes;
    logic       tie;

    typedef struct packed {
        logic [3:0] w;
        logic [7:0] wc;
        logic [9:0] tot;
        logic       tie;
    } res_t;

    res_t expq[$];
    res_t last = '0;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   acc = 0;
    bit   scan_active = 1'b0;
    bit   armed = 1'b0;
    logic [7:0] m [4];

    vote_result_reader dut (
        .clock(clock), .reset(reset), .start(start),
        .vote_result(vote_result), .mode(mode), .button(button),
        .busy(busy), .done(done), .winner(winner),
        .winner_count(winner_count), .total_votes(total_votes), .tie(tie)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Voting machine: returns the selected candidate's count, junk otherwise.
    always_comb begin
        vote_result = 8'hA5;
        for (int k = 0; k < 4; k++)
            if (button == (4'b0001 << k)) vote_result = m[k];
    end

    function automatic res_t model(input int c[4]);
        res_t r;
        int mx = 0;
        int sum = 0;
        int nw = 0;
        for (int k = 0; k < 4; k++) begin
            if (c[k] > mx) mx = c[k];
            sum += c[k];
        end
        r.w = 4'b0000;
        for (int k = 0; k < 4; k++)
            if (c[k] == mx && mx > 0) begin
                r.w[k] = 1'b1;
                nw++;
            end
        r.wc  = 8'(mx);
        r.tot = 10'(sum);
        r.tie = (nw >= 2);
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clock) begin
        if (armed) begin
            int   i;
            int   j;
            int   eb;
            res_t e;
            if (scan_active) begin
                i  = cyc - acc + 1;
                j  = i - MS - 1;
                eb = 0;
                if (j >= 0 && j < 4 * (H + G) && (j % (H + G)) < H)
                    eb = 1 << (j / (H + G));
                check("button", int'(button), eb);
                check("mode", int'(mode), 1);
                check("busy", int'(busy), 1);
                check("done_timing", int'(done), int'(i == LAT));
                if (done) begin
                    if (expq.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL done_unexpected: got done with empty scoreboard");
                    end else begin
                        e = expq.pop_front();
                        check("winner", int'(winner), int'(e.w));
                        check("winner_count", int'(winner_count), int'(e.wc));
                        check("total_votes", int'(total_votes), int'(e.tot));
                        check("tie", int'(tie), int'(e.tie));
                        last = e;
                    end
                    scan_active = 1'b0;
                end
            end else begin
                check("idle_mode", int'(mode), 0);
                check("idle_button", int'(button), 0);
                check("idle_busy", int'(busy), 0);
                check("idle_done", int'(done), 0);
            end
            if (!done) begin
                check("hold_winner", int'(winner), int'(last.w));
                check("hold_count", int'(winner_count), int'(last.wc));
                check("hold_total", int'(total_votes), int'(last.tot));
                check("hold_tie", int'(tie), int'(last.tie));
            end
        end
    end

    task automatic wait_idx(input int target);
        int g = 0;
        do begin
            @(negedge clock);
            g++;
        end while (cyc - acc + 1 != target && g < 500);
    endtask

    task automatic run_scan(input int c[4], input bit inj, input bit abrt, input bit b2b);
        int n = 0;
        @(negedge clock);
        for (int k = 0; k < 4; k++) m[k] = 8'(c[k]);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        acc = cyc;
        scan_active = 1'b1;
        if (!abrt) expq.push_back(model(c));
        if (inj) begin
            wait_idx(MS + (H + G) + 4);
            start = 1'b1;
            @(negedge clock);
            start = 1'b0;
        end
        if (abrt) begin
            wait_idx(MS + 2 * (H + G) + H + 2);
            reset = 1'b1;
            @(posedge clock);
            #1;
            scan_active = 1'b0;
            last = '0;
            @(negedge clock);
            reset = 1'b0;
            return;
        end
        if (b2b) begin
            wait_idx(LAT);
            start = 1'b1;
            return;
        end
        while (scan_active && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (scan_active) begin
            tests++;
            fails++;
            $display("FAIL timeout: no done within %0d cycles", n);
            scan_active = 1'b0;
        end
    endtask

    initial begin
        int a[4];
        for (int k = 0; k < 4; k++) m[k] = 8'd0;
        repeat (2) @(posedge clock);
        #1;
        armed = 1'b1;
        @(negedge clock);
        reset = 1'b0;

        a = '{4, 3, 2, 1};       run_scan(a, 1'b1, 1'b0, 1'b0);
        a = '{3, 3, 0, 1};       run_scan(a, 1'b0, 1'b0, 1'b0);
        a = '{0, 0, 0, 0};       run_scan(a, 1'b0, 1'b0, 1'b0);
        a = '{255, 255, 255, 255}; run_scan(a, 1'b0, 1'b0, 1'b0);
        a = '{7, 8, 9, 10};      run_scan(a, 1'b0, 1'b1, 1'b0);
        a = '{9, 2, 9, 9};       run_scan(a, 1'b0, 1'b0, 1'b1);
        a = '{1, 200, 5, 199};   run_scan(a, 1'b0, 1'b0, 1'b0);

        for (int s = 0; s < 8; s++) begin
            for (int k = 0; k < 4; k++)
                a[k] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3))
                                                    : int'($urandom_range(0, 255));
            run_scan(a, 1'b0, 1'b0, (s == 3));
        end

        repeat (5) @(negedge clock);
        tests++;
        if (expq.size() != 0) begin
            fails++;
            $display("FAIL leftover: got %0d pending results want 0", expq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
